// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between requesters A and B.
// Latency: grant is combinational (0 cycles); read data returns with RVALID one cycle after the grant edge.
// Backpressure: a requester holds REQ/WE/ADDR/WD until it sees GNT; a lock owner may keep the port for at most MAX_LOCK grants.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  // requester A (instruction fetch)
  input  logic          A_REQ,
  input  logic          A_LOCK,
  input  logic          A_WE,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_WD,
  output logic          A_GNT,
  output logic          A_RVALID,
  output logic [DW-1:0] A_RD,
  // requester B (load/store)
  input  logic          B_REQ,
  input  logic          B_LOCK,
  input  logic          B_WE,
  input  logic [AW-1:0] B_ADDR,
  input  logic [DW-1:0] B_WD,
  output logic          B_GNT,
  output logic          B_RVALID,
  output logic [DW-1:0] B_RD,
  // memory port
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WD,
  output logic          M_WE,
  input  logic [DW-1:0] M_RD
);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  // Counter must be able to hold MAX_LOCK itself.
  localparam int            CW      = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);
  localparam bit            MULTI   = (MAX_LOCK > 1);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;          // 0 = A has priority, 1 = B
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;  // 0 = A, 1 = B

  logic          hold_a, hold_b;
  logic          gnt_a, gnt_b;
  logic          win_lock;
  logic [CW-1:0] cnt_inc;

  // Grant selection: lock owner first, then single requester, then priority.
  always_comb begin
    hold_a = (state_q == LOCK_A) & A_REQ & A_LOCK;
    hold_b = (state_q == LOCK_B) & B_REQ & B_LOCK;
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    if (hold_a) begin
      gnt_a = 1'b1;
    end else if (hold_b) begin
      gnt_b = 1'b1;
    end else if (A_REQ & B_REQ) begin
      gnt_a = ~prio_q;
      gnt_b = prio_q;
    end else begin
      gnt_a = A_REQ;
      gnt_b = B_REQ;
    end
  end

  // Memory port follows the winner; write enable is suppressed while in reset.
  always_comb begin
    M_ADDR = '0;
    M_WD   = '0;
    M_WE   = 1'b0;
    if (gnt_a) begin
      M_ADDR = A_ADDR;
      M_WD   = A_WD;
      M_WE   = A_WE & RST_N;
    end else if (gnt_b) begin
      M_ADDR = B_ADDR;
      M_WD   = B_WD;
      M_WE   = B_WE & RST_N;
    end
  end

  // Next state: priority flip, lock tracking and read-return bookkeeping.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = lock_cnt_q + CW'(1);
    win_lock   = gnt_a ? A_LOCK : B_LOCK;

    if (gnt_a | gnt_b) begin
      prio_d = gnt_a;  // the other side gets priority next
    end

    if (hold_a | hold_b) begin
      // Owner keeps the port until the streak reaches MAX_LOCK.
      if (cnt_inc == MAX_CNT) begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = cnt_inc;
      end
    end else if ((gnt_a | gnt_b) & win_lock & MULTI) begin
      state_d    = gnt_a ? LOCK_A : LOCK_B;
      lock_cnt_d = CW'(1);
    end else begin
      state_d    = ARB;
      lock_cnt_d = '0;
    end

    rd_pend_d  = (gnt_a & ~A_WE) | (gnt_b & ~B_WE);
    rd_owner_d = gnt_b;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ARB;
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // RVALID is masked while reset is held so an in-flight read is never reported.
  assign A_GNT    = gnt_a;
  assign B_GNT    = gnt_b;
  assign A_RVALID = rd_pend_q & ~rd_owner_q & RST_N;
  assign B_RVALID = rd_pend_q & rd_owner_q & RST_N;
  assign A_RD     = M_RD;
  assign B_RD     = M_RD;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized traffic
// compared against a behavioural model (grant rules, lock streaks, shadow memory, read return).
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int ML = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          A_REQ, A_LOCK, A_WE, A_GNT, A_RVALID;
  logic [AW-1:0] A_ADDR;
  logic [DW-1:0] A_WD, A_RD;
  logic          B_REQ, B_LOCK, B_WE, B_GNT, B_RVALID;
  logic [AW-1:0] B_ADDR;
  logic [DW-1:0] B_WD, B_RD;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WD, m_rd;
  logic          M_WE;
  logic          load;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ(A_REQ), .A_LOCK(A_LOCK), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WD(A_WD),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RD(A_RD),
    .B_REQ(B_REQ), .B_LOCK(B_LOCK), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WD(B_WD),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RD(B_RD),
    .M_ADDR(M_ADDR), .M_WD(M_WD), .M_WE(M_WE), .M_RD(m_rd)
  );

  function automatic logic [15:0] init_val(int i);
    logic [7:0] lo;
    lo = i[7:0];
    return (i == 16) ? 16'h1234 : {lo, ~lo};
  endfunction

  // Synchronous single-port memory: array and output register update on the same edge.
  logic [DW-1:0] mem [0:255];
  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (M_WE) begin
      mem[M_ADDR] <= M_WD;
    end
    m_rd <= mem[M_ADDR];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] ref_mem [0:255];
  int          m_prio;    // requester that wins a tie
  int          m_own;     // current lock owner, -1 none
  int          m_streak;  // consecutive grants in current lock
  bit          e_pend;
  int          e_owner;
  logic [15:0] e_data;
  int          last_win;

  task automatic model_reset();
    m_prio = 0; m_own = -1; m_streak = 0; e_pend = 0;
  endtask

  // One clock cycle: drive at negedge, check just after, advance the model.
  task automatic step(input bit rst,
                      input bit ar, input bit al, input bit aw, input logic [7:0] aa, input logic [15:0] ad,
                      input bit br, input bit bl, input bit bw, input logic [7:0] ba, input logic [15:0] bd);
    bit rq[2], lk[2], we[2];
    logic [7:0]  adr[2];
    logic [15:0] wd[2];
    int win;
    logic [7:0]  x_addr;
    logic [15:0] x_wd;
    bit          x_we;
    rq[0] = ar; lk[0] = al; we[0] = aw; adr[0] = aa; wd[0] = ad;
    rq[1] = br; lk[1] = bl; we[1] = bw; adr[1] = ba; wd[1] = bd;
    @(negedge CLK);
    RST_N = rst;
    A_REQ = ar; A_LOCK = al; A_WE = aw; A_ADDR = aa; A_WD = ad;
    B_REQ = br; B_LOCK = bl; B_WE = bw; B_ADDR = ba; B_WD = bd;
    #1;
    chk("a_rvalid", A_RVALID, rst && e_pend && e_owner == 0);
    chk("b_rvalid", B_RVALID, rst && e_pend && e_owner == 1);
    if (rst && e_pend && e_owner == 0) chk("a_rd", A_RD, e_data);
    if (rst && e_pend && e_owner == 1) chk("b_rd", B_RD, e_data);

    win = -1;
    if (m_own >= 0 && rq[m_own] && lk[m_own]) win = m_own;
    else if (rq[0] && rq[1])                  win = m_prio;
    else if (rq[0])                           win = 0;
    else if (rq[1])                           win = 1;
    x_addr = '0; x_wd = '0; x_we = 1'b0;
    if (win >= 0) begin
      x_addr = adr[win]; x_wd = wd[win]; x_we = we[win];
    end
    chk("a_gnt", A_GNT, win == 0);
    chk("b_gnt", B_GNT, win == 1);
    chk("m_we", M_WE, rst && x_we);
    chk("m_addr", M_ADDR, x_addr);
    chk("m_wd", M_WD, x_wd);
    last_win = win;

    if (!rst) begin
      model_reset();
    end else begin
      e_pend = 0;
      if (win >= 0) begin
        if (!x_we) begin
          e_pend = 1; e_owner = win; e_data = ref_mem[x_addr];
        end else begin
          ref_mem[x_addr] = x_wd;
        end
        if (m_own == win && lk[win]) begin
          m_streak++;
          if (m_streak == ML) begin m_own = -1; m_streak = 0; end
        end else if (lk[win] && ML > 1) begin
          m_own = win; m_streak = 1;
        end else begin
          m_own = -1; m_streak = 0;
        end
        m_prio = 1 - win;
      end else begin
        m_own = -1; m_streak = 0;
      end
    end
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
  endtask

  bit          r_rq[2], r_lk[2], r_we[2];
  logic [7:0]  r_ad[2];
  logic [15:0] r_wd[2];
  int          r_wait[2];
  int          seq[$];
  int          we_cnt;
  bit          rst_r;

  initial begin
    RST_N = 1'b0; load = 1'b1;
    A_REQ = 0; A_LOCK = 0; A_WE = 0; A_ADDR = '0; A_WD = '0;
    B_REQ = 0; B_LOCK = 0; B_WE = 0; B_ADDR = '0; B_WD = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    repeat (3) @(posedge CLK);
    #1 load = 1'b0;

    // Reset state: no grants, no valids, no write
    idle(0);
    idle(0);

    // Uncontested read of 0x10
    step(1, 1, 0, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    chk("t1_a_gnt", A_GNT, 1);
    chk("t1_m_addr", M_ADDR, 8'h10);
    idle(1);
    chk("t1_a_rvalid", A_RVALID, 1);
    chk("t1_a_rd", A_RD, 16'h1234);

    // Continuous contention without lock alternates A,B,A,B
    idle(0);
    seq.delete();
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 0, 0, 8'h01, 16'h0, 1, 0, 1, 8'h02, 16'h5500 + 16'(k));
      seq.push_back(last_win);
    end
    for (int k = 0; k < 6; k++) chk("t2_alt", seq[k], k % 2);

    // A locked with B contending: A,A,A,A then B
    idle(0);
    seq.delete();
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 1, 0, 8'h03, 16'h0, 1, 0, 0, 8'h04, 16'h0);
      seq.push_back(last_win);
    end
    for (int k = 0; k < 5; k++) chk("t3_lock", seq[k], (k < 4) ? 0 : 1);

    // B write 0xBEEF to 0x22, then read it back
    we_cnt = 0;
    step(1, 0, 0, 0, 8'h00, 16'h0, 1, 0, 1, 8'h22, 16'hBEEF);
    we_cnt += int'(M_WE);
    step(1, 0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h22, 16'h0);
    we_cnt += int'(M_WE);
    idle(1);
    we_cnt += int'(M_WE);
    chk("t4_b_rvalid", B_RVALID, 1);
    chk("t4_b_rd", B_RD, 16'hBEEF);
    chk("t4_we_cnt", we_cnt, 1);

    // Reset right after a read grant drops the return
    step(1, 1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    idle(0);
    chk("t5_a_rvalid", A_RVALID, 0);
    step(1, 1, 0, 0, 8'h06, 16'h0, 1, 0, 0, 8'h07, 16'h0);
    chk("t5_a_wins", last_win, 0);

    // A drops its lock while B waits: B wins, then B holds its own lock
    idle(0);
    step(1, 1, 1, 0, 8'h08, 16'h0, 1, 1, 0, 8'h09, 16'h0);
    chk("t6_a_first", last_win, 0);
    step(1, 1, 0, 0, 8'h0A, 16'h0, 1, 1, 0, 8'h09, 16'h0);
    chk("t6_b_wins", last_win, 1);
    step(1, 1, 0, 0, 8'h0A, 16'h0, 1, 1, 0, 8'h0B, 16'h0);
    chk("t6_b_holds", last_win, 1);

    // Randomized traffic with occasional reset
    idle(0);
    for (int i = 0; i < 2; i++) begin r_rq[i] = 0; r_wait[i] = 0; r_lk[i] = 0; r_we[i] = 0; r_ad[i] = '0; r_wd[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!r_rq[i] && $urandom_range(0, 9) < 6) begin
          r_rq[i] = 1;
          r_we[i] = 1'($urandom_range(0, 1));
          r_ad[i] = 8'($urandom_range(0, 31));
          r_wd[i] = 16'($urandom);
        end
        r_lk[i] = ($urandom_range(0, 9) < 5);
      end
      rst_r = ($urandom_range(0, 199) != 0);
      step(rst_r, r_rq[0], r_lk[0], r_we[0], r_ad[0], r_wd[0],
                  r_rq[1], r_lk[1], r_we[1], r_ad[1], r_wd[1]);
      for (int i = 0; i < 2; i++) begin
        if (!rst_r) begin
          r_wait[i] = 0;
          if (last_win == i) r_rq[i] = 0;
        end else if (r_rq[i]) begin
          if (last_win == i) begin
            chk("wait_bound", r_wait[i] <= ML, 1);
            r_wait[i] = 0;
            r_rq[i] = 0;
          end else begin
            r_wait[i]++;
          end
        end
      end
    end
    idle(1);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
